// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants, request decode type and a constant bin->BCD helper for the BCD counter.
package bcd_mod_counter_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  BCD_MIN     = 4'd0;
  localparam int unsigned MAX_DIGITS  = 8;

  // Winning request on a clock edge after priority resolution (clr > load > en)
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STEP  = 2'd3
  } op_e;

  // Double-dabble for elaboration-time constants; returns up to MAX_DIGITS packed digits
  function automatic logic [31:0] bin_to_bcd32(input logic [31:0] bin);
    logic [63:0] sh;
    sh = {32'd0, bin};
    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
        if (sh[32 + 4*d +: 4] >= 4'd5) sh[32 + 4*d +: 4] = sh[32 + 4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[63:32];
  endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// One decade cell: holds a single BCD digit, steps up/down with 9<->0 rollover, or is set directly.
module bcd_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   dir,
  input  logic                   set,
  input  logic [BCD_DIGIT_W-1:0] set_val,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   is_max,
  output logic                   is_min
);

  logic [BCD_DIGIT_W-1:0] digit_q;
  logic [BCD_DIGIT_W-1:0] digit_d;

  // Next digit: set wins over step; step rolls over within 0..9
  always_comb begin
    digit_d = digit_q;
    if (set) begin
      digit_d = set_val;
    end else if (step) begin
      if (dir) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else     digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit register, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_q <= BCD_MIN;
    else      digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign is_max = (digit_q == BCD_MAX);
  assign is_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-N up/down counter kept both as binary and as packed BCD digits, with wrap/load_err pulses.
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned MODULUS = 1000,
  parameter int unsigned BW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BW-1:0]         load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [BW-1:0]         count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned     BCD_W        = BCD_DIGIT_W * DIGITS;
  localparam logic [BW-1:0]   MOD_VAL      = BW'(MODULUS);
  localparam logic [BW-1:0]   MOD_M1       = BW'(MODULUS - 1);
  localparam logic [31:0]     MOD_M1_BCD32 = bin_to_bcd32(32'(MODULUS - 1));
  localparam logic [BCD_W-1:0] MOD_M1_BCD  = MOD_M1_BCD32[BCD_W-1:0];

  logic [BW-1:0]       count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                lerr_q, lerr_d;

  op_e                 op;
  logic                at_max, at_min, over;
  logic                set_all, step_all;
  logic [BCD_W-1:0]    set_bcd;
  logic [BW-1:0]       conv_in;
  logic [BCD_W+BW-1:0] dd;
  logic [BCD_W-1:0]    ld_bcd;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   is_max, is_min;
  logic [BCD_W-1:0]    digits;
  logic                unused_top_flags;

  assign at_max = (count_q == MOD_M1);
  assign at_min = (count_q == '0);
  assign over   = (load_val >= MOD_VAL);

  // Resolve the request priority for this edge
  always_comb begin
    op = OP_HOLD;
    if      (clr)  op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_STEP;
  end

  // Double-dabble of the (clamped) load value so the digits update on the same edge as count
  always_comb begin
    conv_in = over ? MOD_M1 : load_val;
    dd      = {{BCD_W{1'b0}}, conv_in};
    for (int unsigned i = 0; i < BW; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (dd[BW + 4*d +: 4] >= 4'd5) dd[BW + 4*d +: 4] = dd[BW + 4*d +: 4] + 4'd3;
      end
      dd = dd << 1;
    end
    ld_bcd = dd[BW +: BCD_W];
  end

  // Binary next-state and digit controls; modulus rollover forces digits via set, plain steps ripple
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    lerr_d   = 1'b0;
    set_all  = 1'b0;
    step_all = 1'b0;
    set_bcd  = '0;
    case (op)
      OP_CLEAR: begin
        count_d = '0;
        set_all = 1'b1;
      end
      OP_LOAD: begin
        set_all = 1'b1;
        set_bcd = ld_bcd;
        if (over) begin
          count_d = MOD_M1;
          lerr_d  = 1'b1;
        end else begin
          count_d = load_val;
        end
      end
      OP_STEP: begin
        if (up_dn) begin
          if (at_max) begin
            count_d = '0;
            set_all = 1'b1;
            wrap_d  = 1'b1;
          end else begin
            count_d  = count_q + BW'(1);
            step_all = 1'b1;
          end
        end else begin
          if (at_min) begin
            count_d = MOD_M1;
            set_all = 1'b1;
            set_bcd = MOD_M1_BCD;
            wrap_d  = 1'b1;
          end else begin
            count_d  = count_q - BW'(1);
            step_all = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Carry into digit i: every lower digit sits at its rollover value for the current direction
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      carry[i] = carry[i-1] & (up_dn ? is_max[i-1] : is_min[i-1]);
    end
  end

  // The top digit's flags have no higher digit to feed
  assign unused_top_flags = is_max[DIGITS-1] ^ is_min[DIGITS-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .step    (step_all & carry[g]),
      .dir     (up_dn),
      .set     (set_all),
      .set_val (set_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit   (digits[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .is_max  (is_max[g]),
      .is_min  (is_min[g])
    );
  end

  // Binary count and pulse registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign bcd      = digits;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule
